fwb_slave: RTL and testbench
============================

# fwb_slave

Wishbone (pipelined) bus protocol checker, bound to a slave port such as a memory. It observes the bus and keeps running counts of requests and acknowledgements within the current bus cycle. It constrains master-driven signals with `assume` and checks slave-driven responses with `assert`. It is instantiated only in formal and verification builds and drives no functional logic.

## Interface
- Clocking: one clock; reset is synchronous and active-high (`i_clk`, `i_reset`).
- Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width; select width is `DW/8`.
- `F_LGDEPTH`, default 4: counter width.
- `F_MAX_STALL`, default 0: maximum consecutive stalled cycles; 0 disables the check.
- `F_MAX_ACK_DELAY`, default 0: maximum cycles with a request outstanding and no response; 0 disables the check.
- `F_OPT_DISCONTINUOUS`, default 0: when 1, strobe may drop and rise again within one cycle.
- Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: synchronous active-high reset.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`, in, 1 each: master cycle, strobe and write-enable.
- `i_wb_addr`, in, AW: request address.
- `i_wb_data`, in, DW: slave read data (monitored only).
- `i_wb_sel`, in, DW/8: byte selects.
- `i_wb_ack`, `i_wb_stall`, `i_wb_err`, in, 1 each: slave responses.
- `i_wb_idata`, in, DW: master write data.
- `f_nreqs`, out, F_LGDEPTH: requests accepted in the current cycle.
- `f_nacks`, out, F_LGDEPTH: ack and err responses in the current cycle.
- `f_outstanding`, out, F_LGDEPTH: requests awaiting a response.

## Operation
- `f_past_valid` is 0 at time zero and 1 after the first clock. All `$past`-based properties are gated by it and by not-`$past(i_reset)`.
- A request is accepted when `i_wb_stb && !i_wb_stall`. A response is `i_wb_ack || i_wb_err`.
- Counters, synchronous:
  - Both counters clear on `i_reset` or `!i_wb_cyc`.
  - Otherwise `f_nreqs` increments per accepted request and `f_nacks` increments per response.
  - `f_outstanding = i_wb_cyc ? f_nreqs - f_nacks : 0`, computed combinationally.
- Assumptions on the master:
  - `i_wb_stb` implies `i_wb_cyc`.
  - During `i_reset` and on the cycle after it, `!i_wb_cyc` and `!i_wb_stb`.
  - A stalled request (`$past(cyc & stb & stall)` with `cyc` still high) holds `stb`, `we`, `addr` and `sel` unchanged; `idata` is also unchanged when `we` is set.
  - `we` is constant across back-to-back strobes.
  - After `$past(i_wb_err)`, `!i_wb_cyc`.
  - No new strobe is issued when `f_nreqs` is all ones (no overflow).
  - If `!F_OPT_DISCONTINUOUS`, once `stb` falls inside a cycle it stays low until `cyc` falls.
- Assertions on the slave:
  - Never `ack && err` together.
  - `!ack && !err` on the cycle after `i_reset`, and on any cycle following `!$past(i_wb_cyc)`.
  - When `f_outstanding == 0`, `!ack && !err`; a response is never produced for the request accepted in the same cycle.
  - `f_nacks <= f_nreqs` always, and `f_outstanding` never wraps.
  - If `F_MAX_STALL > 0`, the consecutive-stall counter (clears on `!stb`, `!stall` or reset) stays below `F_MAX_STALL`.
  - If `F_MAX_ACK_DELAY > 0`, the no-response-while-outstanding counter stays below `F_MAX_ACK_DELAY`.
- Simulation builds map `assert` to `$error` and ignore `assume`.

## Timing
- All state updates on the rising edge of `i_clk`. All counters are 0 out of reset.
- Counters reflect events up to the previous edge.
- A zero-stall, one-cycle-latency slave gives the following for stb at cycle T:
  - ack at T+1.
  - At T+1: `f_nreqs=1`, `f_nacks=0`, `f_outstanding=1`.
  - At T+2: `f_nacks=1`, `f_outstanding=0`.
- Simultaneous accept and response in one cycle: both counters increment, so `f_outstanding` is unchanged.
- Reset mid-transaction: counters clear on the next edge. Outstanding requests are discarded.
- Cycle drop (abort) mid-transaction: counters clear on the next edge. Outstanding requests are discarded, and any response on the following cycle is a violation.

## Test plan
- Reset for 2 cycles, idle -> counters 0, no assertion fires.
- Single read: `cyc=stb=1`, `addr=0x10`, `stall=0` at T; slave acks at T+1 -> counters 1/0/1 at T+1, then 1/1/0 at T+2.
- Four pipelined writes, strobe every cycle, ack one cycle later each -> `f_nreqs` reaches 4, `f_nacks` reaches 4, `f_outstanding` peaks at 1; `cyc` drop then clears counters.
- Slave asserts ack with `f_outstanding=0` -> assertion failure in that cycle.
- Slave asserts ack and err together with `f_outstanding=1` -> assertion failure.
- `F_MAX_STALL=3` with the slave stalling 3 consecutive cycles -> assertion failure on the third; 2 cycles of stall passes.

Source files
------------

// File: rtl/fwb_slave.sv
// fwb_slave: pipelined Wishbone protocol checker bound to a slave port.
// Counts requests and responses in the current bus cycle. It also flags
// slave-side protocol violations (reported with $error in simulation) and
// master-side constraint violations (handed to a formal tool as assumptions).
module fwb_slave #(
  parameter int AW                  = 32,
  parameter int DW                  = 32,
  parameter int F_LGDEPTH           = 4,
  parameter int F_MAX_STALL         = 0,
  parameter int F_MAX_ACK_DELAY     = 0,
  parameter bit F_OPT_DISCONTINUOUS = 1'b0,
  parameter bit F_SIM_ERRORS        = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_err,
  input  logic [DW-1:0]        i_wb_idata,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding
);

  // Width of the stall / response-delay run-length counters (saturating).
  localparam int SW = 16;
  localparam logic [SW-1:0] SW_ONE    = SW'(1);
  localparam logic [SW-1:0] STALL_LIM = (F_MAX_STALL > 0) ? SW'(F_MAX_STALL - 1) : '0;
  localparam logic [SW-1:0] WAIT_LIM  = (F_MAX_ACK_DELAY > 0) ? SW'(F_MAX_ACK_DELAY - 1) : '0;

  // Saturating increment so long runs never wrap back below a limit.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == {SW{1'b1}}) ? v : v + SW_ONE;
  endfunction

  logic [F_LGDEPTH-1:0] r_nreqs;
  logic [F_LGDEPTH-1:0] r_nacks;
  logic [SW-1:0]        r_stall_cnt;
  logic [SW-1:0]        r_wait_cnt;
  logic                 r_past_valid;
  logic                 r_past_reset;
  logic                 r_past_cyc;
  logic                 r_past_stb;
  logic                 r_past_stall;
  logic                 r_past_we;
  logic                 r_past_err;
  logic [AW-1:0]        r_past_addr;
  logic [DW/8-1:0]      r_past_sel;
  logic [DW-1:0]        r_past_idata;
  logic                 r_stb_dropped;

  logic                 w_accept;
  logic                 w_resp;
  logic                 w_stb_fell;
  logic                 w_held;
  logic [5:0]           w_viol;
  logic [6:0]           w_asm;
  logic                 w_unused;

  assign w_accept      = i_wb_stb && !i_wb_stall;
  assign w_resp        = i_wb_ack || i_wb_err;
  assign f_nreqs       = r_nreqs;
  assign f_nacks       = r_nacks;
  assign f_outstanding = i_wb_cyc ? (r_nreqs - r_nacks) : '0;

  // Request / response counters, scoped to the current bus cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      r_nreqs <= '0;
      r_nacks <= '0;
    end else begin
      r_nreqs <= r_nreqs + {{(F_LGDEPTH-1){1'b0}}, w_accept};
      r_nacks <= r_nacks + {{(F_LGDEPTH-1){1'b0}}, w_resp};
    end
  end

  // Run lengths of consecutive stalls and of response-less outstanding cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc || !i_wb_stb || !i_wb_stall) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
    if (i_reset || !i_wb_cyc || (f_outstanding == '0) || w_resp) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= sat_inc(r_wait_cnt);
    end
  end

  // One-cycle history of the bus; these mirror inputs so they are never reset.
  always_ff @(posedge i_clk) begin
    r_past_valid <= 1'b1;
    r_past_reset <= i_reset;
    r_past_cyc   <= i_wb_cyc;
    r_past_stb   <= i_wb_stb;
    r_past_stall <= i_wb_stall;
    r_past_we    <= i_wb_we;
    r_past_err   <= i_wb_err;
    r_past_addr  <= i_wb_addr;
    r_past_sel   <= i_wb_sel;
    r_past_idata <= i_wb_idata;
  end

  // Sticky flag: strobe has fallen at some point inside the current cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      r_stb_dropped <= 1'b0;
    end else begin
      r_stb_dropped <= r_stb_dropped || w_stb_fell;
    end
  end

  assign w_stb_fell = r_past_valid && r_past_cyc && r_past_stb && i_wb_cyc && !i_wb_stb;

  // Slave-side checks; one bit per rule.
  assign w_viol[0] = i_wb_ack && i_wb_err;
  assign w_viol[1] = r_past_valid && (r_past_reset || !r_past_cyc) && w_resp;
  assign w_viol[2] = (f_outstanding == '0) && w_resp;
  assign w_viol[3] = r_nacks > r_nreqs;
  assign w_viol[4] = (F_MAX_STALL > 0) && i_wb_cyc && i_wb_stb && i_wb_stall
                     && (r_stall_cnt >= STALL_LIM);
  assign w_viol[5] = (F_MAX_ACK_DELAY > 0) && i_wb_cyc && (f_outstanding != '0)
                     && !w_resp && (r_wait_cnt >= WAIT_LIM);

  // A stalled request must be re-presented unchanged on the next cycle.
  assign w_held = i_wb_stb && (i_wb_we == r_past_we) && (i_wb_addr == r_past_addr)
                  && (i_wb_sel == r_past_sel) && (!i_wb_we || (i_wb_idata == r_past_idata));

  // Master-side constraints; one bit per rule.
  assign w_asm[0] = i_wb_stb && !i_wb_cyc;
  assign w_asm[1] = (i_reset || (r_past_valid && r_past_reset)) && (i_wb_cyc || i_wb_stb);
  assign w_asm[2] = r_past_valid && !r_past_reset && r_past_cyc && r_past_stb && r_past_stall
                    && i_wb_cyc && !w_held;
  assign w_asm[3] = r_past_valid && !r_past_reset && r_past_cyc && r_past_stb && i_wb_cyc
                    && i_wb_stb && (i_wb_we != r_past_we);
  assign w_asm[4] = r_past_valid && !r_past_reset && r_past_err && i_wb_cyc;
  assign w_asm[5] = i_wb_stb && (r_nreqs == {F_LGDEPTH{1'b1}});
  assign w_asm[6] = !F_OPT_DISCONTINUOUS && r_stb_dropped && i_wb_stb;

  // Read data is observed only; fold it away so it is visibly consumed.
  assign w_unused = ^{i_wb_data, w_asm};

  // Report slave-side violations in simulation builds.
  always_ff @(posedge i_clk) begin
    if (F_SIM_ERRORS && r_past_valid) begin
      assert (w_viol == 6'b0)
        else $error("fwb_slave: slave protocol violation, rule bits %b", w_viol);
    end
  end

`ifdef FORMAL
  // Constrain the master and check the slave under a formal tool.
  always @(*) begin
    assume (w_asm == 7'b0);
    if (r_past_valid) begin
      assert (w_viol == 6'b0);
    end
  end
`endif

endmodule

// File: tb/tb_fwb_slave.sv
// tb_fwb_slave: table-driven, hand-written and randomized checks of fwb_slave.
module tb_fwb_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default limits, violations reported; only legal traffic.
  logic        a_rst, a_cyc, a_stb, a_we, a_ack, a_stall, a_err;
  logic [31:0] a_addr, a_data, a_idata;
  logic [3:0]  a_sel;
  logic [3:0]  a_nreqs, a_nacks, a_out;

  // Instance B: stall limit 3, response-delay limit 2, reports silenced.
  logic        b_rst, b_cyc, b_stb, b_we, b_ack, b_stall, b_err;
  logic [31:0] b_addr, b_data, b_idata;
  logic [3:0]  b_sel;
  logic [3:0]  b_nreqs, b_nacks, b_out;

  fwb_slave dut_a (
    .i_clk(clk), .i_reset(a_rst), .i_wb_cyc(a_cyc), .i_wb_stb(a_stb), .i_wb_we(a_we),
    .i_wb_addr(a_addr), .i_wb_data(a_data), .i_wb_sel(a_sel), .i_wb_ack(a_ack),
    .i_wb_stall(a_stall), .i_wb_err(a_err), .i_wb_idata(a_idata),
    .f_nreqs(a_nreqs), .f_nacks(a_nacks), .f_outstanding(a_out)
  );

  fwb_slave #(.F_MAX_STALL(3), .F_MAX_ACK_DELAY(2), .F_SIM_ERRORS(1'b0)) dut_b (
    .i_clk(clk), .i_reset(b_rst), .i_wb_cyc(b_cyc), .i_wb_stb(b_stb), .i_wb_we(b_we),
    .i_wb_addr(b_addr), .i_wb_data(b_data), .i_wb_sel(b_sel), .i_wb_ack(b_ack),
    .i_wb_stall(b_stall), .i_wb_err(b_err), .i_wb_idata(b_idata),
    .f_nreqs(b_nreqs), .f_nacks(b_nacks), .f_outstanding(b_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst, cyc, stb, we, stall, ack, err;
    int nr, na, no;
  } vec_t;

  function automatic vec_t mk(bit rst, bit cyc, bit stb, bit we, bit stall, bit ack, bit err,
                              int nr, int na, int no);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.stall = stall;
    v.ack = ack; v.err = err; v.nr = nr; v.na = na; v.no = no;
    return v;
  endfunction

  task automatic drive_a(input bit rst, input bit cyc, input bit stb, input bit we,
                         input bit stall, input bit ack, input bit err, input logic [31:0] addr);
    a_rst = rst; a_cyc = cyc; a_stb = stb; a_we = we; a_stall = stall;
    a_ack = ack; a_err = err; a_addr = addr; a_sel = 4'hF;
    a_idata = addr ^ 32'hA5A5_0000; a_data = $urandom;
  endtask

  // Drive B for one cycle and compare its violation bits mid-cycle.
  task automatic b_step(input string name, input bit cyc, input bit stb, input bit stall,
                        input bit ack, input bit err, input logic [5:0] exp_viol);
    b_rst = 1'b0; b_cyc = cyc; b_stb = stb; b_stall = stall; b_ack = ack; b_err = err;
    b_we = 1'b0; b_addr = 32'h40; b_sel = 4'hF; b_idata = 32'h0; b_data = $urandom;
    @(negedge clk);
    chk(name, int'(dut_b.w_viol), int'(exp_viol));
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];
  int   q[$];
  int   m_nr, m_na;
  bit   r_cyc, r_stb, r_we, r_stall, r_ack, r_err, err_prev, resp;

  initial begin
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    b_rst = 1'b1; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_stall = 1'b0;
    b_ack = 1'b0; b_err = 1'b0; b_addr = 32'h0; b_sel = 4'h0; b_idata = 32'h0; b_data = 32'h0;
    @(posedge clk); #1;

    // rst cyc stb we stall ack err | nreqs nacks outstanding (seen mid-cycle)
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0));   // second reset cycle
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0));   // idle
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,0));   // single read, T
    tbl.push_back(mk(0,1,0,0,0,1,0, 1,0,1));   // T+1 ack
    tbl.push_back(mk(0,1,0,0,0,0,0, 1,1,0));   // T+2
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,0));   // cyc drops
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0));   // cleared
    tbl.push_back(mk(0,1,1,1,0,0,0, 0,0,0));   // four pipelined writes
    tbl.push_back(mk(0,1,1,1,0,1,0, 1,0,1));   // accept + ack together
    tbl.push_back(mk(0,1,1,1,0,1,0, 2,1,1));
    tbl.push_back(mk(0,1,1,1,0,1,0, 3,2,1));
    tbl.push_back(mk(0,1,0,1,0,1,0, 4,3,1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 4,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 4,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,1,0,0, 0,0,0));   // stalled strobe not counted
    tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1,0, 1,0,1));
    tbl.push_back(mk(0,1,1,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 2,1,1));   // reset mid-transaction
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0));   // abort with request outstanding
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,0));   // error response ends the cycle
    tbl.push_back(mk(0,1,0,0,0,0,1, 1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive_a(tbl[i].rst, tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].stall,
              tbl[i].ack, tbl[i].err, 32'h10 + 32'(i));
      @(negedge clk);
      chk($sformatf("tbl%0d_nreqs", i), int'(a_nreqs), tbl[i].nr);
      chk($sformatf("tbl%0d_nacks", i), int'(a_nacks), tbl[i].na);
      chk($sformatf("tbl%0d_outstanding", i), int'(a_out), tbl[i].no);
      chk($sformatf("tbl%0d_viol", i), int'(dut_a.w_viol), 0);
      @(posedge clk); #1;
    end

    // Hand-written violation sequences on instance B.
    b_step("b_idle",          1, 0, 0, 0, 0, 6'b000000);
    b_step("b_ack_no_req",    1, 0, 0, 1, 0, 6'b000100);
    b_step("b_nacks_gt_reqs", 0, 0, 0, 0, 0, 6'b001000);
    b_step("b_cleared",       0, 0, 0, 0, 0, 6'b000000);
    b_step("b_req",           1, 1, 0, 0, 0, 6'b000000);
    b_step("b_ack_and_err",   1, 0, 0, 1, 1, 6'b000001);
    b_step("b_after_err",     0, 0, 0, 0, 0, 6'b000000);
    b_step("b_stall1",        1, 1, 1, 0, 0, 6'b000000);
    b_step("b_stall2",        1, 1, 1, 0, 0, 6'b000000);
    b_step("b_stall3",        1, 1, 1, 0, 0, 6'b010000);
    b_step("b_stall_release", 1, 1, 0, 0, 0, 6'b000000);
    b_step("b_wait1",         1, 0, 0, 0, 0, 6'b000000);
    b_step("b_wait2",         1, 0, 0, 0, 0, 6'b100000);
    b_step("b_late_ack",      1, 0, 0, 1, 0, 6'b000000);
    b_step("b_2stall_a",      1, 1, 1, 0, 0, 6'b000000);
    b_step("b_2stall_b",      1, 1, 1, 0, 0, 6'b000000);
    b_step("b_2stall_accept", 1, 1, 0, 0, 0, 6'b000000);
    b_step("b_abort",         0, 0, 0, 0, 0, 6'b000000);
    b_step("b_ack_after_abort", 0, 0, 0, 1, 0, 6'b000110);
    b_step("b_quiet",         0, 0, 0, 0, 0, 6'b000000);

    // Randomized legal traffic on instance A against a request-queue model.
    m_nr = 0; m_na = 0; r_cyc = 1'b0; err_prev = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!r_cyc)                                      r_cyc = !err_prev && ($urandom_range(0, 2) == 0);
      else if (err_prev)                               r_cyc = 1'b0;
      else if (q.size() == 0 && $urandom_range(0, 5) == 0) r_cyc = 1'b0;
      else if ($urandom_range(0, 29) == 0)             r_cyc = 1'b0;
      r_stb   = r_cyc && (m_nr < 15) && ($urandom_range(0, 1) == 1);
      r_we    = ($urandom_range(0, 1) == 1);
      r_stall = ($urandom_range(0, 3) == 0);
      resp    = r_cyc && (q.size() > 0) && ($urandom_range(0, 1) == 1);
      r_err   = resp && ($urandom_range(0, 7) == 0);
      r_ack   = resp && !r_err;
      drive_a(1'b0, r_cyc, r_stb, r_we, r_stall, r_ack, r_err, $urandom);
      @(negedge clk);
      chk("rnd_nreqs", int'(a_nreqs), m_nr);
      chk("rnd_nacks", int'(a_nacks), m_na);
      chk("rnd_outstanding", int'(a_out), r_cyc ? q.size() : 0);
      chk("rnd_viol", int'(dut_a.w_viol), 0);
      @(posedge clk); #1;
      if (!r_cyc) begin
        q.delete(); m_nr = 0; m_na = 0;
      end else begin
        if (resp) begin
          void'(q.pop_front());
          m_na++;
        end
        if (r_stb && !r_stall) begin
          q.push_back(int'(a_addr));
          m_nr++;
        end
      end
      err_prev = r_err;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
